// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle: ROM address/data, branch redirect, decode handshake and fault.
//   master : the fetch unit (drives imem_addr, out_*, fault)
//   slave  : the environment (ROM, branch unit, decode)
interface instr_fetch_if;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        br_taken;
  logic [63:0] br_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        fault;

  modport master (
    output imem_addr, out_valid, out_instr, out_pc, fault,
    input  imem_instr, br_taken, br_target, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc, fault,
    output imem_instr, br_taken, br_target, out_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, reads a combinational 32-bit ROM and
// queues {instr, pc} pairs in a small FIFO toward decode. Redirects flush the
// FIFO; misaligned/out-of-range PCs raise a sticky fault that stops fetching.
// Ports:
//   clk      : clock, all state on posedge
//   reset_n  : asynchronous active-low reset
//   bus      : instr_fetch_if.master (imem_*, br_*, out_*, fault)
module instr_fetch #(
  parameter logic [63:0] MEM_SIZE = 64'd1024,
  parameter int unsigned QDEPTH   = 2,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic          clk,
  input  logic          reset_n,
  instr_fetch_if.master bus
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } fetch_entry_t;

  fetch_entry_t     fifo_q [QDEPTH];
  logic [63:0]      pc_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             fault_q;

  logic [64:0]      pc_end_c;
  logic             bad_c;
  logic             full_c;
  logic             deq_c;
  logic             enq_c;

  // Address check and handshake decode; a 65-bit sum makes pc+3 wrap count as bad.
  always_comb begin
    pc_end_c = {1'b0, pc_q} + 65'd3;
    bad_c    = (pc_q[1:0] != 2'b00) || (pc_end_c >= {1'b0, MEM_SIZE});
    full_c   = (count_q == CNT_W'(QDEPTH));
    deq_c    = (count_q != '0) && bus.out_ready;
    enq_c    = !bad_c && !fault_q && !bus.br_taken && (!full_c || deq_c);
  end

  // FIFO storage; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (enq_c) begin
      fifo_q[wr_ptr_q] <= {bus.imem_instr, pc_q};
    end
  end

  // PC, pointers, occupancy and fault; redirect overrides everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      fault_q  <= 1'b0;
    end else if (bus.br_taken) begin
      pc_q     <= bus.br_target;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      if (bad_c && !fault_q) begin
        fault_q <= 1'b1;
      end
      if (enq_c) begin
        pc_q     <= pc_q + 64'd4;
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (deq_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({enq_c, deq_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_instr = fifo_q[rd_ptr_q].instr;
  assign bus.out_pc    = fifo_q[rd_ptr_q].pc;
  assign bus.fault     = fault_q;

`ifndef SYNTHESIS
  // Head must hold while decode stalls; compare against the head seen one edge earlier.
  logic         hold_q;
  fetch_entry_t head_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= 1'b0;
      head_q <= '0;
    end else begin
      if (enq_c) begin
        assert (pc_q[1:0] == 2'b00)
          else $error("enqueue with misaligned pc %h", pc_q);
      end
      if (hold_q) begin
        assert (fifo_q[rd_ptr_q] == head_q)
          else $error("fifo head changed while stalled");
      end
      hold_q <= bus.out_valid && !bus.out_ready && !bus.br_taken;
      head_q <= fifo_q[rd_ptr_q];
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a scoreboard: tests push expected
// {instr, pc} pairs, a negedge monitor pops and compares every accepted head.
// ROM word at byte address A is 0xA0 + A/4 (so mem[16] = 0xB0).
module tb_instr_fetch;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } exp_t;

  logic clk;
  logic reset_n;
  int   compared;
  int   mismatched;
  exp_t sb_q[$];

  instr_fetch_if bus();

  instr_fetch #(
    .MEM_SIZE (64'd1024),
    .QDEPTH   (2),
    .RESET_PC (64'd0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ROM model.
  always_comb begin
    if (bus.imem_addr < 64'd1024) begin
      bus.imem_instr = 32'hA0 + 32'(bus.imem_addr[9:2]);
    end else begin
      bus.imem_instr = 32'hDEADBEEF;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [63:0] pc);
    sb_q.push_back({instr, pc});
  endtask

  // Monitor: every accepted head must match the next expected entry.
  always @(negedge clk) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      compared++;
      if (sb_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_head: got instr %h pc %h, none expected", bus.out_instr, bus.out_pc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (bus.out_instr !== e.instr || bus.out_pc !== e.pc) begin
          mismatched++;
          $display("FAIL head: got instr %h pc %h expected instr %h pc %h",
                   bus.out_instr, bus.out_pc, e.instr, e.pc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    bus.br_taken  = 1'b0;
    bus.br_target = 64'd0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_addr",  bus.imem_addr,      64'd0);
    chk("rst_fault", 64'(bus.fault),     64'd0);
  endtask

  // Keep out_ready as set until the scoreboard empties, then stall decode.
  task automatic drain(input string name);
    for (int n = 0; n < 60; n++) begin
      step();
      if (sb_q.size() == 0) break;
    end
    bus.out_ready = 1'b0;
    chk(name, 64'(sb_q.size()), 64'd0);
  endtask

  task automatic branch(input logic [63:0] target);
    bus.br_taken  = 1'b1;
    bus.br_target = target;
    step();
    bus.br_taken  = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    // 1: streaming after reset, one instruction per cycle.
    do_reset();
    for (int i = 0; i < 8; i++) push(32'hA0 + 32'(i), 64'(i * 4));
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t1_valid_before_edge", 64'(bus.out_valid), 64'd0);
    step();
    chk("t1_valid_after_edge", 64'(bus.out_valid), 64'd1);
    drain("t1_drained");

    // 2: decode stalled for 5 cycles; FIFO full, PC holds.
    do_reset();
    repeat (5) step();
    chk("t2_valid", 64'(bus.out_valid), 64'd1);
    chk("t2_addr",  bus.imem_addr,      64'h8);
    chk("t2_pc",    bus.out_pc,         64'h0);
    chk("t2_instr", 64'(bus.out_instr), 64'hA0);
    for (int i = 0; i < 8; i++) push(32'hA0 + 32'(i), 64'(i * 4));
    bus.out_ready = 1'b1;
    drain("t2_drained");

    // 3: redirect to 0x40 while full with a same-cycle dequeue.
    do_reset();
    repeat (3) step();
    push(32'hA0, 64'h0);
    push(32'hB0, 64'h40);
    push(32'hB1, 64'h44);
    push(32'hB2, 64'h48);
    bus.out_ready = 1'b1;
    branch(64'h40);
    chk("t3_flushed", 64'(bus.out_valid), 64'd0);
    chk("t3_addr",    bus.imem_addr,      64'h40);
    drain("t3_drained");

    // 4: redirect to misaligned 0x42, then recover via redirect to 0x10.
    do_reset();
    branch(64'h42);
    chk("t4_fault_not_yet", 64'(bus.fault), 64'd0);
    step();
    chk("t4_fault",  64'(bus.fault),     64'd1);
    chk("t4_valid",  64'(bus.out_valid), 64'd0);
    chk("t4_addr",   bus.imem_addr,      64'h42);
    repeat (3) step();
    chk("t4_addr_stuck",  bus.imem_addr,      64'h42);
    chk("t4_valid_stuck", 64'(bus.out_valid), 64'd0);
    push(32'hA4, 64'h10);
    push(32'hA5, 64'h14);
    bus.out_ready = 1'b1;
    branch(64'h10);
    chk("t4_fault_cleared", 64'(bus.fault), 64'd0);
    drain("t4_drained");

    // 5: walk off the end of a 1 KiB ROM.
    do_reset();
    branch(64'h3F8);
    repeat (2) step();
    chk("t5_no_fault_at_3fc", 64'(bus.fault), 64'd0);
    chk("t5_addr_400",        bus.imem_addr,  64'h400);
    step();
    chk("t5_fault",      64'(bus.fault),     64'd1);
    chk("t5_addr_holds", bus.imem_addr,      64'h400);
    chk("t5_valid",      64'(bus.out_valid), 64'd1);
    push(32'h19E, 64'h3F8);
    push(32'h19F, 64'h3FC);
    bus.out_ready = 1'b1;
    drain("t5_drained");
    repeat (3) step();
    chk("t5_empty_after",  64'(bus.out_valid), 64'd0);
    chk("t5_fault_sticky", 64'(bus.fault),     64'd1);

    // 6: asynchronous reset mid-cycle with FIFO full.
    do_reset();
    repeat (3) step();
    chk("t6_full_valid", 64'(bus.out_valid), 64'd1);
    chk("t6_full_addr",  bus.imem_addr,      64'h8);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_async_addr",  bus.imem_addr,      64'd0);
    chk("t6_async_fault", 64'(bus.fault),     64'd0);
    chk("t6_sb_empty",    64'(sb_q.size()),   64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
